system_top: RTL and testbench

FPGA top level for the microprocessor board demo. It models clock-manager lock and gates the system reset until lock is reached. It runs a 16-bit free-running value counter and drives it as 4 hex digits on a time-multiplexed, active-low 7-segment display.

---
 rtl/system_top_if.sv | 19 +
 rtl/system_top.sv | 141 ++++++++++++++
 tb/tb_system_top.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/system_top_if.sv
// Display-side bundle of the board demo top: 7-seg anodes, segments, lock flag.
// Driven by system_top (master), observed by the board pins / bench (slave).
interface system_top_if;
  logic [3:0] SEG_SELECT_OUT;
  logic [7:0] HEX_OUT;
  logic       MMCM_LOCKED;

  modport master (
    output SEG_SELECT_OUT,
    output HEX_OUT,
    output MMCM_LOCKED
  );

  modport slave (
    input SEG_SELECT_OUT,
    input HEX_OUT,
    input MMCM_LOCKED
  );
endinterface

// File: rtl/system_top.sv
// Board demo top: modelled clock-manager lock, gated reset, hex counter on 7-seg.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module system_top #(
  parameter int LOCK_CYCLES = 1000,
  parameter int REFRESH_DIV = 1000,
  parameter int COUNT_DIV   = 10000
) (
  input  logic CLK100_IN,
  input  logic HARD_RSTN,
  system_top_if.master disp_if
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int CW = $clog2(COUNT_DIV + 1);

  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;
  logic [1:0]    sync_q;
  logic          sys_rst_n;

  logic [CW-1:0] cpre_q, cpre_d;
  logic [15:0]   value_q, value_d;
  logic [RW-1:0] rpre_q, rpre_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    hex_q, hex_d;

  logic          cwrap, rwrap;
  logic [3:0]    nib;
  logic          blank;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    unique case (d)
      4'h0: s = 8'hC0;
      4'h1: s = 8'hF9;
      4'h2: s = 8'hA4;
      4'h3: s = 8'hB0;
      4'h4: s = 8'h99;
      4'h5: s = 8'h92;
      4'h6: s = 8'h82;
      4'h7: s = 8'hF8;
      4'h8: s = 8'h80;
      4'h9: s = 8'h90;
      4'hA: s = 8'h88;
      4'hB: s = 8'h83;
      4'hC: s = 8'hC6;
      4'hD: s = 8'hA1;
      4'hE: s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!locked_q) begin
      if (lock_cnt_q == LW'(LOCK_CYCLES - 1))
        locked_d = 1'b1;
      else
        lock_cnt_d = lock_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK100_IN or negedge HARD_RSTN) begin
    if (!HARD_RSTN) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // locked_q only falls with HARD_RSTN, so this is the synchronised AND
  always_ff @(posedge CLK100_IN or negedge HARD_RSTN) begin
    if (!HARD_RSTN)
      sync_q <= 2'b00;
    else
      sync_q <= {sync_q[0], locked_q};
  end

  assign sys_rst_n = sync_q[1];

  always_comb begin
    cwrap   = (cpre_q == CW'(COUNT_DIV - 1));
    rwrap   = (rpre_q == RW'(REFRESH_DIV - 1));
    cpre_d  = cwrap ? '0 : cpre_q + 1'b1;
    rpre_d  = rwrap ? '0 : rpre_q + 1'b1;
    value_d = value_q + {15'd0, cwrap};
    idx_d   = idx_q + {1'b0, rwrap};
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    unique case (idx_q)
      2'd0: nib = value_q[3:0];
      2'd1: nib = value_q[7:4];
      2'd2: nib = value_q[11:8];
      default: nib = value_q[15:12];
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    unique case (1'b1)
      (idx_q == 2'd3): blank = (value_q[15:12] == 4'h0);
      (idx_q == 2'd2): blank = (value_q[15:8] == 8'h00);
      (idx_q == 2'd1): blank = (value_q[15:4] == 12'h000);
      default:         blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    sel_d = ~(4'b0001 << idx_q);
    hex_d = blank ? 8'hFF : seg7(nib);
  end

  always_ff @(posedge CLK100_IN or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cpre_q  <= '0;
      rpre_q  <= '0;
      value_q <= 16'h0000;
      idx_q   <= 2'd0;
      sel_q   <= 4'b1111;
      hex_q   <= 8'hFF;
    end else begin
      cpre_q  <= cpre_d;
      rpre_q  <= rpre_d;
      value_q <= value_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      hex_q   <= hex_d;
    end
  end

  assign disp_if.SEG_SELECT_OUT = sel_q;
  assign disp_if.HEX_OUT        = hex_q;
  assign disp_if.MMCM_LOCKED    = locked_q;

endmodule

// File: tb/tb_system_top.sv
// Scoreboard bench for system_top: default-rate instance plus a fast wrap instance.
// Expectations are queued by cycle number and checked by a negedge monitor.
module tb_system_top;

  localparam int R    = 5000;
  localparam int L1   = 1000;
  localparam int L2   = 4;
  localparam int B1   = R + L1 + 3;
  localparam int P    = B1 + 63500;
  localparam int E1   = P + 1 + L1 + 3;
  localparam int ENDC = E1 + 5000;
  localparam int B2   = R + L2 + 3;

  typedef struct {
    int         cyc;
    string      nm;
    logic [3:0] seg;
    logic [7:0] hex;
    logic       lck;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  logic clk;
  logic rst1;
  logic rst2;
  int   cyc;
  int   checks;
  int   errors;
  logic [3:0] sel_tab [4];

  system_top_if if1();
  system_top_if if2();

  system_top #(
    .LOCK_CYCLES(L1),
    .REFRESH_DIV(1000),
    .COUNT_DIV(10000)
  ) u_main (
    .CLK100_IN(clk),
    .HARD_RSTN(rst1),
    .disp_if(if1)
  );

  system_top #(
    .LOCK_CYCLES(L2),
    .REFRESH_DIV(1),
    .COUNT_DIV(1)
  ) u_wrap (
    .CLK100_IN(clk),
    .HARD_RSTN(rst2),
    .disp_if(if2)
  );

  initial begin
    clk = 1'b0;
    cyc = 0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    logic [7:0] t [16];
    t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[d];
  endfunction

  function automatic logic [7:0] hex_exp(input logic [15:0] v, input int idx);
    logic [15:0] hi;
    hi = v >> (4 * idx);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx != 0 && hi == 16'h0000) return 8'hFF;
`endif
    return seg_of(hi[3:0]);
  endfunction

  task automatic push(input int dut, input int c, input string nm,
                      input logic [3:0] s, input logic [7:0] h, input logic l);
    exp_t e;
    e.cyc = c;
    e.nm  = nm;
    e.seg = s;
    e.hex = h;
    e.lck = l;
    if (dut == 1) q1.push_back(e);
    else q2.push_back(e);
  endtask

  task automatic push_run(input int dut, input string nm, input int base,
                          input int n, input int cdiv, input int rdiv);
    int idx;
    logic [15:0] v;
    idx = (n / rdiv) % 4;
    v   = 16'(n / cdiv);
    push(dut, base + n, nm, sel_tab[idx], hex_exp(v, idx), 1'b1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc != c) @(negedge clk);
  endtask

  task automatic chk(input exp_t e, input logic [3:0] s,
                     input logic [7:0] h, input logic l);
    checks++;
    if (s !== e.seg || h !== e.hex || l !== e.lck) begin
      errors++;
      $display("FAIL %s @cyc %0d: got sel=%b hex=%h lock=%b, want sel=%b hex=%h lock=%b",
               e.nm, cyc, s, h, l, e.seg, e.hex, e.lck);
    end
  endtask

  initial begin
    sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
        e = q1.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missed at cyc %0d (now %0d)", e.nm, e.cyc, cyc);
        end else begin
          chk(e, if1.SEG_SELECT_OUT, if1.HEX_OUT, if1.MMCM_LOCKED);
        end
      end
      while (q2.size() > 0 && q2[0].cyc <= cyc) begin
        e = q2.pop_front();
        if (e.cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL %s missed at cyc %0d (now %0d)", e.nm, e.cyc, cyc);
        end else begin
          chk(e, if2.SEG_SELECT_OUT, if2.HEX_OUT, if2.MMCM_LOCKED);
        end
      end
      if ((cyc >= B1 && cyc < P) || (cyc >= E1 && cyc <= ENDC)) begin
        checks++;
        if ($countones(~if1.SEG_SELECT_OUT) != 1) begin
          errors++;
          $display("FAIL onehot @cyc %0d: got sel=%b, want exactly one low bit",
                   cyc, if1.SEG_SELECT_OUT);
        end
      end
    end
  end

  initial begin : wrap_stim
    rst2 = 1'b0;
    push(2, 10, "w_rst", 4'hF, 8'hFF, 1'b0);
    push(2, R + L2 - 1, "w_prelock", 4'hF, 8'hFF, 1'b0);
    push(2, R + L2, "w_lock", 4'hF, 8'hFF, 1'b1);
    push_run(2, "w_n0", B2, 0, 1, 1);
    push_run(2, "w_n4", B2, 4, 1, 1);
    push_run(2, "w_00A6", B2, 166, 1, 1);
    push_run(2, "w_00AD", B2, 173, 1, 1);
    push_run(2, "w_1235", B2, 4661, 1, 1);
    push_run(2, "w_FFFE", B2, 65534, 1, 1);
    push_run(2, "w_FFFF_d3", B2, 65535, 1, 1);
    push_run(2, "w_0000", B2, 65536, 1, 1);
    push_run(2, "w_0003_d3", B2, 65539, 1, 1);
    wait_cyc(R);
    rst2 = 1'b1;
  end

  initial begin : main_stim
    checks = 0;
    errors = 0;
    rst1   = 1'b0;
    push(1, 1, "rst_hold_a", 4'hF, 8'hFF, 1'b0);
    push(1, R / 2, "rst_hold_b", 4'hF, 8'hFF, 1'b0);
    push(1, R, "rst_hold_c", 4'hF, 8'hFF, 1'b0);
    push(1, R + L1 - 1, "prelock", 4'hF, 8'hFF, 1'b0);
    push(1, R + L1, "lock_edge", 4'hF, 8'hFF, 1'b1);
    push(1, R + L1 + 1, "blank_after_lock", 4'hF, 8'hFF, 1'b1);
    push_run(1, "first_digit", B1, 0, 10000, 1000);
    push_run(1, "scan_999", B1, 999, 10000, 1000);
    push_run(1, "scan_1000", B1, 1000, 10000, 1000);
    push_run(1, "scan_1999", B1, 1999, 10000, 1000);
    push_run(1, "scan_2000", B1, 2000, 10000, 1000);
    push_run(1, "scan_2999", B1, 2999, 10000, 1000);
    push_run(1, "scan_3000", B1, 3000, 10000, 1000);
    push_run(1, "scan_3999", B1, 3999, 10000, 1000);
    push_run(1, "scan_4000", B1, 4000, 10000, 1000);
    push_run(1, "v0_end", B1, 9999, 10000, 1000);
    push_run(1, "v1_start", B1, 10000, 10000, 1000);
    push_run(1, "v1_d0", B1, 12000, 10000, 1000);
    push_run(1, "v5_end", B1, 59999, 10000, 1000);
    push_run(1, "v6_d0", B1, 60000, 10000, 1000);
    push_run(1, "v6_d0_late", B1, 60999, 10000, 1000);
    push_run(1, "v6_d1", B1, 61000, 10000, 1000);
    push_run(1, "v6_d2", B1, 62000, 10000, 1000);
    push_run(1, "v6_d3", B1, 63000, 10000, 1000);
    wait_cyc(R);
    rst1 = 1'b1;

    push(1, P, "pulse_async", 4'hF, 8'hFF, 1'b0);
    push(1, P + 1, "pulse_hold", 4'hF, 8'hFF, 1'b0);
    push(1, P + L1, "relock_pre", 4'hF, 8'hFF, 1'b0);
    push(1, P + L1 + 1, "relock", 4'hF, 8'hFF, 1'b1);
    push_run(1, "restart_d0", E1, 0, 10000, 1000);
    push_run(1, "restart_d1", E1, 1000, 10000, 1000);
    push_run(1, "restart_5k", E1, 5000, 10000, 1000);
    wait_cyc(P - 1);
    @(posedge clk);
    #2 rst1 = 1'b0;
    @(posedge clk);
    #2 rst1 = 1'b1;

    wait_cyc(ENDC + 2);
    while (q1.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (cyc %0d)", q1[0].nm, q1[0].cyc);
      void'(q1.pop_front());
    end
    while (q2.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s never checked (cyc %0d)", q2[0].nm, q2[0].cyc);
      void'(q2.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
